// File: rtl/gin_mcast_fifo.sv
// Multicast delivery FIFO for a PE array.
// Buffers tagged transactions and strobes every matching PE at once.
module gin_mcast_fifo #(
  parameter int DATA_WIDTH    = 64,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 4,
  parameter int NUM_OF_ROWS   = 12,
  parameter int NUM_OF_COLS   = 14,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [ROW_TAG_WIDTH-1:0] in_row_tag,
  input  logic [COL_TAG_WIDTH-1:0] in_col_tag,
  input  logic in_bcast,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [NUM_OF_ROWS-1:0][ROW_TAG_WIDTH-1:0] row_id,
  input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][COL_TAG_WIDTH-1:0] col_id,
  input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] pe_ready,
  output logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] pe_valid,
  output logic [DATA_WIDTH-1:0] pe_data,
  output logic nomatch_err,
  output logic [15:0] tx_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ROW_TAG_WIDTH-1:0] row;
    logic [COL_TAG_WIDTH-1:0] col;
    logic bcast;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  typedef logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] pe_vec_t;

  ent_t mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;

  pe_vec_t pe_valid_q;
  logic [DATA_WIDTH-1:0] pe_data_q;
  logic nomatch_q;
  logic [15:0] tx_q;

  ent_t head;
  pe_vec_t tgt;
  logic any_tgt, all_rdy, empty;
  logic push, deliver, discard, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (cnt_q == '0);
  assign in_ready = (cnt_q < CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_q];

  // Target mask of the head entry: broadcast or row/column ID match.
  always_comb begin
    tgt = '0;
    for (int r = 0; r < NUM_OF_ROWS; r++) begin
      for (int c = 0; c < NUM_OF_COLS; c++) begin
        tgt[r][c] = head.bcast ||
          (row_id[r] == head.row && col_id[r][c] == head.col);
      end
    end
  end

  // Deliver only when every target is ready; untargeted heads are dropped.
  assign any_tgt = |tgt;
  assign all_rdy = &(~tgt | pe_ready);
  assign deliver = !empty && any_tgt && all_rdy;
  assign discard = !empty && !any_tgt;
  assign pop     = deliver || discard;

  // Occupancy next state.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // Buffer storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= '{in_row_tag, in_col_tag, in_bcast, in_data};
        wr_q <= nxt(wr_q);
      end
      if (pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_d;
    end
  end

  // Registered delivery strobes, payload, error pulse and counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pe_valid_q <= '0;
      pe_data_q  <= '0;
      nomatch_q  <= 1'b0;
      tx_q       <= '0;
    end else begin
      pe_valid_q <= deliver ? tgt : '0;
      nomatch_q  <= discard;
      if (deliver) begin
        pe_data_q <= head.data;
        tx_q      <= tx_q + 16'd1;
      end
    end
  end

  assign pe_valid    = pe_valid_q;
  assign pe_data     = pe_data_q;
  assign nomatch_err = nomatch_q;
  assign tx_count    = tx_q;

endmodule

// File: tb/tb_gin_mcast_fifo.sv
// Bench for gin_mcast_fifo.
// Scoreboard of expected deliveries plus directed timing checks.
module tb_gin_mcast_fifo;
  localparam int R = 12;
  localparam int C = 14;
  localparam int N = R * C;

  logic clk = 0;
  logic reset = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [3:0] in_row_tag = 0;
  logic [3:0] in_col_tag = 0;
  logic in_bcast = 0;
  logic [63:0] in_data = 0;
  logic [R-1:0][3:0] rid;
  logic [R-1:0][C-1:0][3:0] cid;
  logic [R-1:0][C-1:0] rdy;
  logic [R-1:0][C-1:0] pe_valid;
  logic [63:0] pe_data;
  logic nomatch_err;
  logic [15:0] tx_count;

  gin_mcast_fifo dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_row_tag(in_row_tag), .in_col_tag(in_col_tag),
    .in_bcast(in_bcast), .in_data(in_data),
    .row_id(rid), .col_id(cid), .pe_ready(rdy),
    .pe_valid(pe_valid), .pe_data(pe_data),
    .nomatch_err(nomatch_err), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] mask;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int evq[$];
  int cyc = 0;
  int n_tot = 0;
  int n_bad = 0;
  logic [15:0] exp_tx = 0;
  logic [N-1:0] ones;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] tgt(input logic [3:0] rt,
      input logic [3:0] ct, input logic bc);
    logic [N-1:0] m;
    m = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        m[r*C+c] = bc || (rid[r] == rt && cid[r][c] == ct);
    return m;
  endfunction

  function automatic logic [N-1:0] bit1(input int r, input int c);
    logic [N-1:0] m;
    m = '0;
    m[r*C+c] = 1'b1;
    return m;
  endfunction

  // Pop and compare one expected result per output event.
  always @(negedge clk) begin
    if (reset && (|pe_valid || nomatch_err)) begin
      exp_t e;
      evq.push_back(cyc);
      if (sb.size() == 0) chk("unexp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("mask", pe_valid, e.mask);
        chk("nomatch", nomatch_err, e.mask == '0);
        if (e.mask != '0) begin
          chk("data", pe_data, e.data);
          exp_tx = exp_tx + 16'd1;
        end
        chk("txcnt", tx_count, exp_tx);
      end
    end
  end

  task automatic push(input logic [3:0] rt, input logic [3:0] ct,
                      input logic bc, input logic [63:0] d);
    int w;
    exp_t e;
    w = 0;
    in_valid = 1;
    in_row_tag = rt;
    in_col_tag = ct;
    in_bcast = bc;
    in_data = d;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("push_to", 0, 1);
    else begin
      e.mask = tgt(rt, ct, bc);
      e.data = d;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    ones = '1;
    for (int r = 0; r < R; r++) begin
      rid[r] = 4'(r);
      for (int c = 0; c < C; c++) cid[r][c] = 4'(c);
    end
    rdy = '1;

    repeat (3) @(negedge clk);
    chk("rst_valid", pe_valid, 0);
    chk("rst_data", pe_data, 0);
    chk("rst_nm", nomatch_err, 0);
    chk("rst_tx", tx_count, 0);
    chk("rst_rdy", in_ready, 1);
    reset = 1;
    @(negedge clk);

    // single unicast, latency accept+2
    push(4'd3, 4'd5, 1'b0, 64'hA5);
    chk("lat1", pe_valid, 0);
    @(negedge clk);
    chk("lat2", pe_valid, bit1(3, 5));
    chk("lat2_data", pe_data, 64'hA5);
    chk("lat2_tx", tx_count, 1);

    // broadcast stalled by one PE
    rdy[7][2] = 0;
    push(4'd0, 4'd0, 1'b1, 64'h1234);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bc_stall", pe_valid, 0);
    end
    rdy[7][2] = 1;
    @(negedge clk);
    chk("bc_all", pe_valid, ones);
    chk("bc_tx", tx_count, 2);
    chk("bc_hold", pe_data, 64'h1234);
    @(negedge clk);
    chk("data_hold", pe_data, 64'h1234);

    // no-match discard then next entry proceeds
    push(4'd15, 4'd0, 1'b0, 64'h77);
    push(4'd2, 4'd3, 1'b0, 64'h88);
    chk("nm_pulse", nomatch_err, 1);
    chk("nm_novalid", pe_valid, 0);
    @(negedge clk);
    chk("nm_next", pe_valid, bit1(2, 3));
    chk("nm_clr", nomatch_err, 0);
    chk("nm_tx", tx_count, 3);
    drain();

    // fill to full, hold fifth, back-to-back drain
    rdy = '0;
    for (int i = 0; i < 4; i++)
      push(4'(i), 4'(i), 1'b0, 64'h100 + 64'(i));
    chk("full_rdy", in_ready, 0);
    in_valid = 1;
    in_row_tag = 4'd4;
    in_col_tag = 4'd4;
    in_bcast = 0;
    in_data = 64'h104;
    repeat (2) begin
      @(negedge clk);
      chk("full_hold", in_ready, 0);
    end
    chk("full_novalid", pe_valid, 0);
    evq.delete();
    rdy = '1;
    push(4'd4, 4'd4, 1'b0, 64'h104);
    drain();
    chk("b2b_n", evq.size(), 5);
    if (evq.size() >= 4)
      for (int i = 1; i < 4; i++)
        chk("b2b_gap", evq[i] - evq[i-1], 1);

    // duplicate IDs: multicast, all-or-nothing
    cid[0][0] = 4'd2;
    cid[0][1] = 4'd2;
    cid[0][2] = 4'd15;
    push(4'd0, 4'd2, 1'b0, 64'hBEEF);
    @(negedge clk);
    chk("dup_both", pe_valid, bit1(0, 0) | bit1(0, 1));
    rdy[0][1] = 0;
    push(4'd0, 4'd2, 1'b0, 64'hCAFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dup_none", pe_valid, 0);
    end
    rdy[0][1] = 1;
    @(negedge clk);
    chk("dup_rel", pe_valid, bit1(0, 0) | bit1(0, 1));
    drain();

    // reset with buffered entries
    rdy = '0;
    for (int i = 0; i < 3; i++)
      push(4'd5, 4'd5, 1'b0, 64'h200 + 64'(i));
    #1;
    reset = 0;
    sb.delete();
    exp_tx = 0;
    #1;
    chk("mr_tx", tx_count, 0);
    chk("mr_data", pe_data, 0);
    chk("mr_valid", pe_valid, 0);
    chk("mr_nm", nomatch_err, 0);
    @(negedge clk);
    reset = 1;
    rdy = '1;
    chk("mr_rdy", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mr_quiet", pe_valid, 0);
    end
    push(4'd1, 4'd1, 1'b0, 64'h55);
    @(negedge clk);
    chk("mr_new", pe_valid, bit1(1, 1));
    chk("mr_newtx", tx_count, 1);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/gin_mcast_fifo.md
GIN_MCAST_FIFO -- requirements
Module: gin_mcast_fifo

Interface
REQ-001 DATA_WIDTH, 64, payload bits per transaction.
REQ-002 ROW_TAG_WIDTH, 4, row tag/ID width.
REQ-003 COL_TAG_WIDTH, 4, column tag/ID width.
REQ-004 NUM_OF_ROWS, 12, PE array rows.
REQ-005 NUM_OF_COLS, 14, PE array columns.
REQ-006 FIFO_DEPTH, 4, input buffer entries; legal range 2..16.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset; asserted when 0.
REQ-009 in_valid  in  1  source offers a transaction.
REQ-010 in_ready  out  1  block accepts a transaction this cycle.
REQ-011 in_row_tag  in  ROW_TAG_WIDTH  destination row tag.
REQ-012 in_col_tag  in  COL_TAG_WIDTH  destination column tag.
REQ-013 in_bcast  in  1  1 = deliver to every PE, tags ignored.
REQ-014 in_data  in  DATA_WIDTH  payload.
REQ-015 row_id  in  ROW_TAG_WIDTH x NUM_OF_ROWS  per-row ID, static during operation.
REQ-016 col_id  in  COL_TAG_WIDTH x NUM_OF_ROWS x NUM_OF_COLS  per-PE column ID, static.
REQ-017 pe_ready  in  NUM_OF_ROWS x NUM_OF_COLS  PE can accept data.
REQ-018 pe_valid  out  NUM_OF_ROWS x NUM_OF_COLS  registered one-cycle delivery strobe per PE.
REQ-019 pe_data  out  DATA_WIDTH  registered payload shared by all PEs.
REQ-020 nomatch_err  out  1  registered one-cycle pulse: head transaction matched no PE.
REQ-021 tx_count  out  16  delivered-transaction counter.

Function
REQ-022 Accept: transaction {row_tag, col_tag, bcast, data} pushed when in_valid && in_ready; in_ready = (occupancy < FIFO_DEPTH), independent of in_valid.
REQ-023 Occupancy counter width $clog2(FIFO_DEPTH+1); simultaneous push and pop leaves occupancy unchanged; circular read/write pointers wrap from FIFO_DEPTH-1 to 0.
REQ-024 Match: PE (r,c) targeted by head when head.bcast=1, or (row_id[r]==head.row_tag && col_id[r][c]==head.col_tag); multiple PEs sharing IDs are all targeted (multicast).
REQ-025 Delivery condition at cycle T: FIFO non-empty, at least one target, and pe_ready high for every target; non-targeted pe_ready ignored.
REQ-026 On delivery at T: head popped; at T+1 pe_valid high exactly for targets, pe_data = head.data, tx_count incremented by 1 (wraps 0xFFFF->0).
REQ-027 If head has zero targets: popped at T, nomatch_err high at T+1, no pe_valid, tx_count unchanged.
REQ-028 If any target not ready: head held, pe_valid all 0 at T+1, retried every cycle; no partial delivery.
REQ-029 Throughput: one delivery or discard per cycle when conditions hold; minimum latency accept (cycle N) to pe_valid = N+2.
REQ-030 Push into full FIFO coinciding with pop: not accepted (in_ready already 0 that cycle).
REQ-031 pe_data holds last delivered value when pe_valid all 0.
REQ-032 Ordering strictly FIFO; a stalled head blocks all later transactions.

Reset
REQ-033 reset=0 asynchronously clears: occupancy 0, pointers 0, pe_valid all 0, pe_data 0, nomatch_err 0, tx_count 0; in_ready=1 once reset=1 (FIFO empty).
REQ-034 Reset mid-operation discards all buffered transactions; nothing delivered after release until new pushes.

Verification
REQ-035 All pe_ready=1, row_id[r]=r, col_id[r][c]=c; push row 3, col 5, data 0xA5 -> pe_valid[3][5] only, 2 cycles after accept, pe_data 0xA5, tx_count 1.
REQ-036 in_bcast=1, data 0x1234, pe_ready[7][2]=0 for 5 cycles -> no pe_valid for 5 cycles, then all 168 pe_valid high in one cycle, tx_count +1.
REQ-037 Push row tag 15 (no row ID 15) -> nomatch_err one cycle, no pe_valid, tx_count unchanged, next entry proceeds.
REQ-038 All pe_ready=0, push FIFO_DEPTH=4 entries -> in_ready 0 after 4th; 5th held; release ready -> 4 deliveries in 4 consecutive cycles, in original order.
REQ-039 Two PEs with identical IDs (0,0)/(0,1) col_id=2 -> both strobed same cycle; if one not ready, neither strobed.
REQ-040 Assert reset with 3 entries buffered -> all outputs zero immediately, after release no pe_valid until new push, tx_count 0.
